// File: rtl/poly_mod_reduce_if.sv
// ---------------------------------------------------------------------------
// poly_mod_reduce_if
// Groups the control handshake, the product-memory read port and the
// ModpolyN write port of poly_mod_reduce into one bundle.
//
// Signals:
//   start     begin a reduction (sampled by the reducer only when idle)
//   busy      reducer is running
//   done      one-cycle pulse after the final coefficient write
//   src_addr  read address into the product memory
//   src_data  product coefficient, combinational read of src_addr
//   dst_we    ModpolyN write enable
//   dst_addr  ModpolyN write address
//   dst_data  reduced coefficient in [0,Q)
//
// Modports:
//   master  the reducer side (drives addresses, writes and status)
//   slave   the environment side (drives start and the source data)
// ---------------------------------------------------------------------------
interface poly_mod_reduce_if #(
    parameter int unsigned COEF_W = 13,
    parameter int unsigned ADDR_W = 11
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_addr;
    logic [COEF_W-1:0] src_data;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [COEF_W-1:0] dst_data;

    modport master (
        input  start,
        input  src_data,
        output busy,
        output done,
        output src_addr,
        output dst_we,
        output dst_addr,
        output dst_data
    );

    modport slave (
        output start,
        output src_data,
        input  busy,
        input  done,
        input  src_addr,
        input  dst_we,
        input  dst_addr,
        input  dst_data
    );
endinterface

// File: rtl/poly_mod_reduce.sv
// ---------------------------------------------------------------------------
// poly_mod_reduce
// Reduces a raw product polynomial c(x) (degree <= 2P-2, coefficients < Q)
// modulo x^P - x - 1 and modulo Q, and streams the P reduced coefficients
// into the ModpolyN coefficient RAM.
//
// Since x^P = x + 1, coefficient r_i = c_i + c_{P+i} + c_{P+i-1} (mod Q),
// where c_{P-1} is not a high term for i=0 and c_{2P-1} is zero. Each index
// takes two cycles: one to read c_i, one to read c_{P+i}. The high term read
// for index i is kept as prev_hi and reused as c_{P+i} for index i+1, so each
// source word is read only once.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   poly_mod_reduce_if master modport:
//           start/busy/done handshake, src_addr/src_data asynchronous-read
//           source port, dst_we/dst_addr/dst_data registered write port
// ---------------------------------------------------------------------------
module poly_mod_reduce #(
    parameter int unsigned P      = 761,
    parameter int unsigned Q      = 4591,
    parameter int unsigned COEF_W = 13,
    parameter int unsigned ADDR_W = 11
) (
    input logic                clk,
    input logic                rst,
    poly_mod_reduce_if.master  bus
);

    localparam int unsigned       SumW    = COEF_W + 2;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(P - 1);
    localparam logic [ADDR_W-1:0] HiBase  = ADDR_W'(P);
    localparam logic [SumW-1:0]   QExt    = SumW'(Q);

    typedef enum logic [1:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [COEF_W-1:0] acc_q, acc_d;
    logic [COEF_W-1:0] prev_hi_q, prev_hi_d;
    logic              dst_we_q, dst_we_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic [COEF_W-1:0] dst_data_q, dst_data_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] src_addr;
    logic [COEF_W-1:0] hi;
    logic [SumW-1:0]   sum;
    logic [SumW-1:0]   sub1;
    logic [SumW-1:0]   sub2;
    logic [COEF_W-1:0] red;

    // ------------------------------------------------------------------
    // Modular reduction datapath. With all three terms < Q the sum is
    // below 3Q, so two conditional subtractions always land in [0,Q).
    // ------------------------------------------------------------------
    always_comb begin
        // c_{2P-1} does not exist: the last index has no fresh high term.
        hi   = (idx_q == LastIdx) ? '0 : bus.src_data;
        sum  = SumW'(acc_q) + SumW'(hi) + SumW'(prev_hi_q);
        sub1 = (sum >= QExt) ? (sum - QExt) : sum;
        sub2 = (sub1 >= QExt) ? (sub1 - QExt) : sub1;
        red  = COEF_W'(sub2);
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        prev_hi_d  = prev_hi_q;
        dst_we_d   = 1'b0;
        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
        done_d     = 1'b0;
        src_addr   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    idx_d     = '0;
                    prev_hi_d = '0;
                    state_d   = StRdLo;
                end
            end
            StRdLo: begin
                src_addr = idx_q;
                acc_d    = bus.src_data;
                state_d  = StRdHi;
            end
            StRdHi: begin
                src_addr   = HiBase + idx_q;
                dst_we_d   = 1'b1;
                dst_addr_d = idx_q;
                dst_data_d = red;
                prev_hi_d  = hi;
                if (idx_q == LastIdx) begin
                    state_d = StFin;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StRdLo;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_q      <= '0;
            prev_hi_q  <= '0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            prev_hi_q  <= prev_hi_d;
            dst_we_q   <= dst_we_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.src_addr = src_addr;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.dst_we   = dst_we_q;
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_data = dst_data_q;

    // Writes are spaced two cycles apart and done is a single pulse.
    a_we_pulse : assert property (@(posedge clk) disable iff (rst) dst_we_q |=> !dst_we_q);
    a_done_pulse : assert property (@(posedge clk) disable iff (rst) done_q |=> !done_q);

endmodule

// File: tb/tb_poly_mod_reduce.sv
// ---------------------------------------------------------------------------
// tb_poly_mod_reduce
// Self-checking bench for poly_mod_reduce. The source memory is an array
// read combinationally; expected coefficients come from the direct formula
// r_i = (c_i + c_{P+i} + c_{P+i-1}) mod Q with out-of-range terms as zero.
// ---------------------------------------------------------------------------
module tb_poly_mod_reduce;

    localparam int unsigned P        = 761;
    localparam int unsigned Q        = 4591;
    localparam int unsigned COEF_W   = 13;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned MemDepth = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_mod_reduce_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

    logic [COEF_W-1:0] mem [MemDepth];
    assign bus.src_data = mem[bus.src_addr];

    poly_mod_reduce #(
        .P      (P),
        .Q      (Q),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned exp_r [P];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    // Reference: plain polynomial arithmetic with x^P = x + 1.
    function automatic void build_model();
        for (int i = 0; i < int'(P); i++) begin
            longint unsigned s;
            s = mem[i];
            if (P + i <= 2 * P - 2) s += mem[P+i];
            if (i >= 1) s += mem[P+i-1];
            exp_r[i] = int'(s % Q);
        end
    endfunction

    function automatic void fill_const(input int unsigned v);
        for (int k = 0; k < int'(MemDepth); k++) mem[k] = COEF_W'(v);
    endfunction

    function automatic void fill_random();
        for (int k = 0; k < int'(MemDepth); k++) mem[k] = COEF_W'($urandom_range(0, Q - 1));
    endfunction

    // Launches a run from a negedge and follows it to done. Optionally
    // pulses start at cycle 300 (must be ignored) and optionally raises
    // start in the done cycle to chain the next run.
    task automatic run(input string tag, input bit pulse300, input bit chain);
        int n;
        int idx;
        bit seen_done;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        idx = 0;
        seen_done = 1'b0;
        bus.start = 1'b0;
        check_eq({tag, "_busy"}, bus.busy, 1);
        while (!seen_done && n <= int'(2 * P + 20)) begin
            if (pulse300 && n == 300) bus.start = 1'b1;
            if (pulse300 && n == 301) bus.start = 1'b0;
            if (bus.dst_we) begin
                if (idx < int'(P)) begin
                    check_eq({tag, "_wr_addr"}, bus.dst_addr, idx);
                    check_eq({tag, "_wr_data"}, bus.dst_data, exp_r[idx]);
                    check_eq({tag, "_wr_cyc"}, n, 2 * idx + 3);
                    check_eq({tag, "_lt_q"}, bus.dst_data < COEF_W'(Q), 1);
                end else begin
                    check_eq({tag, "_extra_wr"}, idx + 1, P);
                end
                idx++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check_eq({tag, "_done_cyc"}, n, 2 * P + 2);
                check_eq({tag, "_n_writes"}, idx, P);
                if (chain) bus.start = 1'b1;
            end
            if (!seen_done) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq({tag, "_done_seen"}, seen_done, 1);
        if (!chain) begin
            @(negedge clk);
            check_eq({tag, "_done_pulse"}, bus.done, 0);
            check_eq({tag, "_idle"}, bus.busy, 0);
            check_eq({tag, "_we_idle"}, bus.dst_we, 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_we"}, bus.dst_we, 0);
        check_eq({tag, "_addr"}, bus.dst_addr, 0);
        check_eq({tag, "_data"}, bus.dst_data, 0);
    endtask

    // Asserts reset in the middle of a run while a write is on the port.
    task automatic run_abort(input int abort_at);
        int n;
        int writes;
        int late;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        writes = 0;
        bus.start = 1'b0;
        while (n < abort_at) begin
            if (bus.dst_we) writes++;
            @(negedge clk);
            n++;
        end
        check_eq("abort_pre_writes", writes, (abort_at - 1) / 2 - 1);
        check_eq("abort_we_before", bus.dst_we, 1);
        rst = 1'b1;
        #1;
        check_reset_state("abort_rst");
        late = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.dst_we) late++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.dst_we || bus.busy) late++;
        end
        check_eq("abort_no_late_wr", late, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        fill_const(0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("por");

        // x^761 = x + 1
        fill_const(0);
        mem[P] = 1;
        build_model();
        run("one_hi", 1'b0, 1'b0);

        // x^1520 = x^760 + x^759
        fill_const(0);
        mem[2*P-2] = 1;
        build_model();
        run("top", 1'b0, 1'b0);

        // Reset while idle after a run that left dst_addr at P-1
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("idle_rst");
        rst = 1'b0;
        @(negedge clk);

        fill_const(Q - 1);
        build_model();
        run("sat", 1'b0, 1'b0);

        // Random data, ignored mid-run start, back-to-back identical run
        fill_random();
        build_model();
        run("rand_a", 1'b1, 1'b1);
        run("rand_b", 1'b0, 1'b0);

        fill_random();
        build_model();
        run_abort(501);
        run("post_abort", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_mod_reduce.md
Name: poly_mod_reduce

Overview:
- Upstream producer for the ModpolyN coefficient RAM. Reads a raw product polynomial c(x) of degree ≤ 2P-2 from an asynchronous-read source memory.
- Reduces it modulo x^P - x - 1 and modulo Q, then writes the P reduced coefficients into the ModpolyN RAM through its synchronous write port.
- Sits between the polynomial multiplier's product buffer and ModpolyN in the SNTRUP757 datapath.

Parameters:
- P, 761, polynomial degree bound; result has P coefficients.
- Q, 4591, coefficient modulus.
- COEF_W, 13, coefficient width; equals ModpolyN RAM_WIDTH.
- ADDR_W, 11, address width of source and destination; 2^ADDR_W ≥ 2P-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a reduction; sampled only in IDLE
- busy  out  1  high while state ≠ IDLE
- done  out  1  one-cycle pulse after the last coefficient is written
- src_addr  out  ADDR_W  read address into the product memory
- src_data  in  COEF_W  product coefficient; combinational (same-cycle) read of src_addr; values < Q
- dst_we  out  1  write enable to ModpolyN
- dst_addr  out  ADDR_W  ModpolyN write address
- dst_data  out  COEF_W  reduced coefficient, in [0,Q)

Behaviour:
- Maths, using x^P = x + 1:
  - r_i = (c_i + c_{P+i} + c_{P+i-1}) mod Q for 0 ≤ i ≤ P-1.
  - c_{P-1} is never used as the high term for i=0; that term is 0.
  - c_{2P-1} is out of range and is 0 (affects i=P-1).
  - Net: r_0 = c_0 + c_P; r_{P-1} = c_{P-1} + c_{2P-2}.
- Arithmetic:
  - Sum held at COEF_W+2 bits; sum < 3Q.
  - Reduction: subtract Q if sum ≥ Q, then subtract Q again if still ≥ Q.
  - Inputs ≥ Q are out of contract; the result is then the two-subtraction value truncated to COEF_W bits (deterministic).
- State machine:
  - States IDLE, RD_LO, RD_HI, FIN. Index register i (ADDR_W bits); register prev_hi (COEF_W bits).
  - IDLE: src_addr=0. On start=1, set i←0, prev_hi←0, go to RD_LO.
  - RD_LO: src_addr=i; acc←src_data; go to RD_HI.
  - RD_HI: src_addr=P+i. hi is src_data, or 0 when i=P-1. Compute r = reduce(acc + hi + prev_hi).
  - RD_HI registers dst_we←1, dst_addr←i, dst_data←r, and prev_hi←hi.
  - RD_HI next state: if i=P-1 go to FIN, else i←i+1 and go to RD_LO.
  - FIN: registers done←1 and goes to IDLE.
- Output registers:
  - dst_we, dst_addr, dst_data and done are registered outputs.
  - dst_we and done are high for exactly one cycle per event.
  - dst_addr and dst_data hold their last value when dst_we=0.
- Timing (start sampled at edge 0):
  - RD_LO in cycle 2i+1, RD_HI in cycle 2i+2, dst_we high in cycle 2i+3.
  - Last write in cycle 2P+1; done high in cycle 2P+2.
  - Total 2P+2 cycles (1524 for P=761).
  - Writes go to ascending addresses 0..P-1, one every two cycles, each exactly once.
- Simultaneous and boundary events:
  - start while busy=1 is ignored.
  - start is sampled again in the cycle done is high, since the state is IDLE then; this allows back-to-back runs.
  - start held high continuously restarts immediately after each done.
- Reset:
  - Any time, including mid-run: state←IDLE; i, acc, prev_hi←0; dst_we, done←0; dst_addr, dst_data←0; busy←0.
  - Writes already issued are not undone. No partial write is issued after reset asserts.
  - A following start performs a complete, correct run.

Test Plan:
- Reset: assert rst for 3 cycles mid-simulation with start=0 → busy=0, done=0, dst_we=0, dst_addr=0, dst_data=0.
- Single high term: c_761=1, all others 0 → r_0=1, r_1=1, every other r_i=0 (x^761 = x+1).
- Top term: c_1520=1, all others 0 → r_760=1, r_759=1, all others 0.
- Saturation: every c_k=4590 → r_0=4589, r_760=4589, r_1..r_759=4588; all dst_data < 4591.
- Timing/handshake:
  - Random c: results match the golden model.
  - dst_we pulses exactly 761 times at addresses 0..760 ascending.
  - done is high exactly 1524 cycles after start.
  - A start pulse at cycle 300 is ignored.
  - A start in the done cycle launches a second identical run.
- Reset mid-run: assert rst at cycle 500 → dst_we drops immediately and no further writes occur; a new start then completes with correct r_0..r_760.
